// File: rtl/uart_rx_core.sv
// UART receiver core: synchronises rx_i, deserialises start/data/parity/stop frames and
// presents each byte on a valid/ready output with parity, frame and overrun status.
module uart_rx_core #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned SYNC_FF = 2
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             parity_en_i,
    input  logic             parity_type_i,
    input  logic             stop2_i,
    input  logic [3:0]       data_bits_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SYNC_FF-1:0] sync_r;
    logic               rx_s;
    logic [DIV_W-1:0]   cnt_r;
    logic [DIV_W-1:0]   div_r;
    logic [3:0]         nbits_r;
    logic [3:0]         nbits_cfg_s;
    logic               par_en_r;
    logic               par_type_r;
    logic               stop2_r;
    logic [7:0]         shift_r;
    logic [3:0]         idx_r;
    logic               perr_r;
    logic               ferr_r;
    logic               tick_s;
    logic               last_bit_s;
    logic               div_ok_s;
    logic               start_s;
    logic               complete_s;
    logic               accept_s;
    logic               frame_ferr_s;
    logic [7:0]         rx_data_r;
    logic               rx_valid_r;
    logic               parity_err_r;
    logic               frame_err_r;
    logic               overrun_r;
    logic               busy_r;

    // Parity over the assembled data byte; unused upper bits are always zero.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        calc_parity = (^data) ^ odd;
    endfunction

    assign rx_s       = sync_r[SYNC_FF-1];
    assign tick_s     = (cnt_r == CNT_ZERO);
    assign last_bit_s = (idx_r == (nbits_r - 4'd1));
    assign div_ok_s   = |clk_div_i[DIV_W-1:2];
    assign accept_s   = (~rx_valid_r) | rx_ready_i;
    // The stop bit being sampled in the completing cycle still counts toward the frame error.
    assign frame_ferr_s = ferr_r | ~rx_s;

    // Data-bit count decode: anything outside 5..8 means 8.
    always_comb begin
        nbits_cfg_s = 4'd8;
        case (data_bits_i)
            4'd5:    nbits_cfg_s = 4'd5;
            4'd6:    nbits_cfg_s = 4'd6;
            4'd7:    nbits_cfg_s = 4'd7;
            4'd8:    nbits_cfg_s = 4'd8;
            default: nbits_cfg_s = 4'd8;
        endcase
    end

    // rx_i synchroniser, preset to the idle line level.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_r <= {SYNC_FF{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_FF-2:0], rx_i};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s && div_ok_s) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (rx_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && last_bit_s) begin
                    if (par_en_r) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_STOP1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_nxt_s = ST_STOP1;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (tick_s) begin
                    if (stop2_r) begin
                        state_nxt_s = ST_STOP2;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        complete_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (tick_s) begin
                    state_nxt_s = ST_IDLE;
                    complete_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP2;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit timer: half a bit to the start-bit centre, then a full bit per sample.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_r <= CNT_ZERO;
        end else if (start_s) begin
            cnt_r <= {1'b0, clk_div_i[DIV_W-1:1]};
        end else if (state_r != ST_IDLE) begin
            if (tick_s) begin
                cnt_r <= div_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Frame configuration snapshot taken at the start edge.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            div_r      <= CNT_ZERO;
            nbits_r    <= 4'd8;
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
            stop2_r    <= 1'b0;
        end else if (start_s) begin
            div_r      <= clk_div_i;
            nbits_r    <= nbits_cfg_s;
            par_en_r   <= parity_en_i;
            par_type_r <= parity_type_i;
            stop2_r    <= stop2_i;
        end else begin
            div_r      <= div_r;
            nbits_r    <= nbits_r;
            par_en_r   <= par_en_r;
            par_type_r <= par_type_r;
            stop2_r    <= stop2_r;
        end
    end

    // Data assembly and per-frame error accumulation.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            shift_r <= 8'h00;
            idx_r   <= 4'd0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else if (start_s) begin
            shift_r <= 8'h00;
            idx_r   <= 4'd0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else if (tick_s) begin
            case (state_r)
                ST_DATA: begin
                    shift_r[idx_r[2:0]] <= rx_s;
                    idx_r               <= idx_r + 4'd1;
                end
                ST_PARITY: begin
                    perr_r <= rx_s ^ calc_parity(shift_r, par_type_r);
                end
                ST_STOP1, ST_STOP2: begin
                    ferr_r <= frame_ferr_s;
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end else begin
            shift_r <= shift_r;
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (complete_s && accept_s) begin
            rx_data_r    <= shift_r;
            rx_valid_r   <= 1'b1;
            parity_err_r <= perr_r;
            frame_err_r  <= frame_ferr_s;
            overrun_r    <= 1'b0;
        end else if (complete_s) begin
            overrun_r    <= 1'b1;
        end else if (rx_valid_r && rx_ready_i) begin
            rx_valid_r   <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r    <= 1'b0;
        end
    end

    // Busy flag registered from the next state so it tracks state_r exactly.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign rx_data_o    = rx_data_r;
    assign rx_valid_o   = rx_valid_r;
    assign parity_err_o = parity_err_r;
    assign frame_err_o  = frame_err_r;
    assign overrun_o    = overrun_r;
    assign busy_o       = busy_r;

endmodule
